// File: rtl/updown_counter.sv
// Up/down counter with synchronous parallel load, count enable and async reset.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             direction,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load,
  output logic [WIDTH-1:0] cout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;

  // Priority below reset: load, then count in the selected direction, else hold.
  always_comb begin
    // NOTE: default first so every path assigns cnt_next and no latch is inferred.
    cnt_next = cnt;
    if (load) begin
      cnt_next = parallel_in;
    end else if (enable) begin
      if (direction) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
        if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;
`else
        cnt_next = cnt + 1'b1;
`endif
      end else begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
        if (cnt != CNT_MIN) cnt_next = cnt - 1'b1;
`else
        cnt_next = cnt - 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep register updates race-free across processes.
    if (reset) cnt <= CNT_MIN;
    else       cnt <= cnt_next;
  end

  assign cout = cnt;

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (WIDTH = 4, 100 ns clock).
// Expected values follow UPDOWN_COUNTER_SATURATE_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_updown_counter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             direction;
  logic [WIDTH-1:0] parallel_in;
  logic             load;
  logic [WIDTH-1:0] cout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  updown_counter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .direction   (direction),
    .parallel_in (parallel_in),
    .load        (load),
    .cout        (cout)
  );

  always #50 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; direction = 1'b1; load = 1'b0; parallel_in = '0;
    tick();
    total_cnt++;
    if (cout !== 4'd0) $display("FAIL reset_state: got %0d expected 0", cout);
    else pass_cnt++;
    reset = 1'b0;
    parallel_in = 4'd9; load = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++;
    if (cout !== 4'd9) $display("FAIL reset_preload: got %0d expected 9", cout);
    else pass_cnt++;
    #20 reset = 1'b1;
    #1;
    total_cnt++;
    if (cout !== 4'd0) $display("FAIL reset_async: got %0d expected 0 before edge", cout);
    else pass_cnt++;
    #10 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (cout !== 4'd0) $display("FAIL reset_release_hold[%0d]: got %0d expected 0", i, cout);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_count();
    logic [WIDTH-1:0] exp_seq [3] = '{4'd7, 4'd8, 4'd9};
    parallel_in = 4'd6; load = 1'b1; enable = 1'b1; direction = 1'b1;
    tick();
    total_cnt++;
    if (cout !== 4'd6) $display("FAIL load: got %0d expected 6", cout);
    else pass_cnt++;
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (cout !== exp_seq[i]) $display("FAIL count_up[%0d]: got %0d expected %0d", i, cout, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_held_load();
    parallel_in = 4'd6; load = 1'b1; enable = 1'b1; direction = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total_cnt++;
      if (cout !== 4'd6) $display("FAIL held_load[%0d]: got %0d expected 6", i, cout);
      else pass_cnt++;
    end
    load = 1'b0;
    tick();
    total_cnt++;
    if (cout !== 4'd7) $display("FAIL held_load_release: got %0d expected 7", cout);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
`ifdef UPDOWN_COUNTER_SATURATE_EN
    logic [WIDTH-1:0] up_seq [3] = '{4'd15, 4'd15, 4'd15};
    logic [WIDTH-1:0] dn_seq [3] = '{4'd0, 4'd0, 4'd0};
`else
    logic [WIDTH-1:0] up_seq [3] = '{4'd15, 4'd0, 4'd1};
    logic [WIDTH-1:0] dn_seq [3] = '{4'd0, 4'd15, 4'd14};
`endif
    parallel_in = 4'd14; load = 1'b1; enable = 1'b1; direction = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++;
    if (cout !== 4'd14) $display("FAIL wrap_load14: got %0d expected 14", cout);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (cout !== up_seq[i]) $display("FAIL wrap_up[%0d]: got %0d expected %0d", i, cout, up_seq[i]);
      else pass_cnt++;
    end
    // Start the down leg from 1 in both builds so the low limit is reached.
    parallel_in = 4'd1; load = 1'b1;
    tick();
    load = 1'b0; direction = 1'b0;
    total_cnt++;
    if (cout !== 4'd1) $display("FAIL wrap_load1: got %0d expected 1", cout);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (cout !== dn_seq[i]) $display("FAIL wrap_down[%0d]: got %0d expected %0d", i, cout, dn_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_direction_change();
    logic [WIDTH-1:0] exp_seq [4] = '{4'd11, 4'd12, 4'd11, 4'd12};
    logic             dir_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    parallel_in = 4'd10; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      direction = dir_seq[i];
      tick();
      total_cnt++;
      if (cout !== exp_seq[i]) $display("FAIL dir_change[%0d]: got %0d expected %0d", i, cout, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_gating();
    parallel_in = 4'd5; load = 1'b1; enable = 1'b1; direction = 1'b1;
    tick();
    load = 1'b0; enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      direction = ~direction;
      tick();
      total_cnt++;
      if (cout !== 4'd5) $display("FAIL enable_gating[%0d]: got %0d expected 5", i, cout);
      else pass_cnt++;
    end
  endtask

  task automatic test_priority();
    parallel_in = 4'd3; load = 1'b1; enable = 1'b1; direction = 1'b1;
    tick();
    total_cnt++;
    if (cout !== 4'd3) $display("FAIL load_over_count: got %0d expected 3", cout);
    else pass_cnt++;
    parallel_in = 4'd3; load = 1'b1; enable = 1'b1; direction = 1'b0;
    tick();
    total_cnt++;
    if (cout !== 4'd3) $display("FAIL load_over_down: got %0d expected 3", cout);
    else pass_cnt++;
    parallel_in = 4'd7; reset = 1'b1;
    tick();
    total_cnt++;
    if (cout !== 4'd0) $display("FAIL reset_over_load: got %0d expected 0", cout);
    else pass_cnt++;
    reset = 1'b0; load = 1'b0; direction = 1'b1;
    tick();
    total_cnt++;
    if (cout !== 4'd1) $display("FAIL restart_after_reset: got %0d expected 1", cout);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_count();
    test_held_load();
    test_wrap();
    test_direction_change();
    test_enable_gating();
    test_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
